// File: rtl/lane_deskew.sv
// rtl/lane_deskew.sv - two-lane alignment-marker deskew with registered aligned outputs
//
// Purpose:
//   Finds the alignment marker (ALIGN_SYM) on each decoded lane, measures the
//   lane-to-lane skew in byte clocks and delays the early lane so both lanes
//   leave byte-aligned. Reports valid/done/error status to link training.
//
// Parameters:
//   MAX_SKEW  - largest tolerated skew in byte clocks (1..15)
//   ALIGN_SYM - alignment marker byte value, same on both lanes
//
// Optional feature macro: LANE_DESKEW_RELOCK_EN
//   When defined, a locked link that shows the marker on exactly one aligned
//   output lane drops lock and returns to SEARCH.
//
// Ports:
//   i_enc_clk         byte clock, all logic on rising edge
//   i_rst             synchronous active-low reset
//   i_enable_deskew   start/hold deskew; low returns the block to IDLE
//   i_lane_0_rx       decoded byte, lane 0
//   i_lane_1_rx       decoded byte, lane 1
//   i_data_os         data(1)/ordered-set(0) tag common to both lanes
//   o_lane_0_out      aligned byte, lane 0
//   o_lane_1_out      aligned byte, lane 1
//   o_data_os_out     i_data_os delayed one cycle
//   o_rx_valid        aligned outputs valid
//   o_deskew_done     high while LOCKED
//   o_deskew_err      skew exceeded MAX_SKEW; held until enable drops
//   o_skew_lane       lane being delayed (0 when skew is zero)
//   o_skew_val        delay applied to o_skew_lane, in byte clocks

module lane_deskew #(
   parameter int         MAX_SKEW  = 7,
   parameter logic [7:0] ALIGN_SYM = 8'hF0
) (
   input  logic       i_enc_clk,
   input  logic       i_rst,
   input  logic       i_enable_deskew,
   input  logic [7:0] i_lane_0_rx,
   input  logic [7:0] i_lane_1_rx,
   input  logic       i_data_os,
   output logic [7:0] o_lane_0_out,
   output logic [7:0] o_lane_1_out,
   output logic       o_data_os_out,
   output logic       o_rx_valid,
   output logic       o_deskew_done,
   output logic       o_deskew_err,
   output logic       o_skew_lane,
   output logic [3:0] o_skew_val
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEARCH  = 3'd1,
      S_MEASURE = 3'd2,
      S_LOCKED  = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_early;
   logic       r_skew_lane;
   logic [3:0] r_skew_val;
   logic       r_rx_valid;
   logic       r_deskew_done;
   logic       r_deskew_err;
   logic       r_data_os_out;
   logic [7:0] r_lane_0_out;
   logic [7:0] r_lane_1_out;

   // Per-lane delay lines; element i holds the byte received i+1 cycles ago.
   logic [7:0] r_sr0 [MAX_SKEW];
   logic [7:0] r_sr1 [MAX_SKEW];

   logic [7:0] w_del0;
   logic [7:0] w_del1;
   logic       w_mk0;
   logic       w_mk1;
   logic       w_mk_other;

   assign w_mk0      = (i_lane_0_rx == ALIGN_SYM);
   assign w_mk1      = (i_lane_1_rx == ALIGN_SYM);
   // Marker on the lane that has not yet shown one (the late lane).
   assign w_mk_other = r_early ? w_mk0 : w_mk1;

   // Tap selection: skew_val of zero passes the live input straight through.
   always_comb begin
      w_del0 = i_lane_0_rx;
      w_del1 = i_lane_1_rx;
      for (int i = 0; i < MAX_SKEW; i++) begin
         if (r_skew_val == 4'(i + 1)) begin
            w_del0 = r_sr0[i];
            w_del1 = r_sr1[i];
         end
      end
   end

`ifdef LANE_DESKEW_RELOCK_EN
   logic w_out_mk0;
   logic w_out_mk1;
   assign w_out_mk0 = (r_lane_0_out == ALIGN_SYM);
   assign w_out_mk1 = (r_lane_1_out == ALIGN_SYM);
`endif

   always_ff @(posedge i_enc_clk) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_early       <= 1'b0;
         r_skew_lane   <= 1'b0;
         r_skew_val    <= '0;
         r_rx_valid    <= 1'b0;
         r_deskew_done <= 1'b0;
         r_deskew_err  <= 1'b0;
         r_data_os_out <= 1'b0;
         r_lane_0_out  <= '0;
         r_lane_1_out  <= '0;
         for (int i = 0; i < MAX_SKEW; i++) begin
            r_sr0[i] <= '0;
            r_sr1[i] <= '0;
         end
      end else begin
         // Delay lines and output mux run in every state.
         r_sr0[0] <= i_lane_0_rx;
         r_sr1[0] <= i_lane_1_rx;
         for (int i = 1; i < MAX_SKEW; i++) begin
            r_sr0[i] <= r_sr0[i-1];
            r_sr1[i] <= r_sr1[i-1];
         end
         r_lane_0_out  <= (r_skew_lane == 1'b0) ? w_del0 : i_lane_0_rx;
         r_lane_1_out  <= (r_skew_lane == 1'b1) ? w_del1 : i_lane_1_rx;
         r_data_os_out <= i_data_os;

         if (!i_enable_deskew) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rx_valid    <= 1'b0;
            r_deskew_done <= 1'b0;
            r_deskew_err  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_SEARCH;
                  r_cnt   <= '0;
               end

               S_SEARCH: begin
                  if (w_mk0 && w_mk1) begin
                     r_skew_val    <= '0;
                     r_skew_lane   <= 1'b0;
                     r_deskew_done <= 1'b1;
                     r_state       <= S_LOCKED;
                  end else if (w_mk0 || w_mk1) begin
                     r_early <= w_mk1;
                     r_cnt   <= 4'd1;
                     r_state <= S_MEASURE;
                  end
               end

               S_MEASURE: begin
                  // The late lane's marker wins over the MAX_SKEW limit on
                  // the same cycle, so a skew of exactly MAX_SKEW locks.
                  if (w_mk_other) begin
                     r_skew_lane   <= r_early;
                     r_skew_val    <= r_cnt;
                     r_deskew_done <= 1'b1;
                     r_state       <= S_LOCKED;
                  end else if (r_cnt == 4'(MAX_SKEW)) begin
                     r_deskew_err <= 1'b1;
                     r_state      <= S_ERROR;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end

               S_LOCKED: begin
                  r_deskew_done <= 1'b1;
                  r_rx_valid    <= 1'b1;
`ifdef LANE_DESKEW_RELOCK_EN
                  // Only judged once rx_valid is up: the outputs produced on
                  // the lock-entry edge still used the previous tap setting.
                  if (r_rx_valid && (w_out_mk0 ^ w_out_mk1)) begin
                     r_rx_valid    <= 1'b0;
                     r_deskew_done <= 1'b0;
                     r_skew_val    <= '0;
                     r_skew_lane   <= 1'b0;
                     r_state       <= S_SEARCH;
                  end
`endif
               end

               S_ERROR: begin
                  r_deskew_err <= 1'b1;
                  r_rx_valid   <= 1'b0;
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_lane_0_out  = r_lane_0_out;
   assign o_lane_1_out  = r_lane_1_out;
   assign o_data_os_out = r_data_os_out;
   assign o_rx_valid    = r_rx_valid;
   assign o_deskew_done = r_deskew_done;
   assign o_deskew_err  = r_deskew_err;
   assign o_skew_lane   = r_skew_lane;
   assign o_skew_val    = r_skew_val;

endmodule

// File: tb/tb_lane_deskew.sv
// tb/tb_lane_deskew.sv - self-checking bench for lane_deskew

module tb_lane_deskew;

   localparam int MAXS = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [7:0] l0_rx = 8'h00;
   logic [7:0] l1_rx = 8'h00;
   logic       dos = 1'b0;
   logic [7:0] l0_out;
   logic [7:0] l1_out;
   logic       dos_out;
   logic       rx_valid;
   logic       done;
   logic       err;
   logic       skew_lane;
   logic [3:0] skew_val;

   lane_deskew #(.MAX_SKEW(MAXS), .ALIGN_SYM(8'hF0)) dut (
      .i_enc_clk       (clk),
      .i_rst           (rst),
      .i_enable_deskew (en),
      .i_lane_0_rx     (l0_rx),
      .i_lane_1_rx     (l1_rx),
      .i_data_os       (dos),
      .o_lane_0_out    (l0_out),
      .o_lane_1_out    (l1_out),
      .o_data_os_out   (dos_out),
      .o_rx_valid      (rx_valid),
      .o_deskew_done   (done),
      .o_deskew_err    (err),
      .o_skew_lane     (skew_lane),
      .o_skew_val      (skew_val)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference: every input byte ever driven, indexed by clock edge. The
   // delayed lane's output after edge k is its input from edge k-skew.
   logic [7:0] h0 [0:4095];
   logic [7:0] h1 [0:4095];
   logic       hd [0:4095];
   int         cyc = 0;
   int         m_lane = 0;
   int         m_val = 0;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'hF0) b = 8'h5A;
      return b;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock: drive, clock, sample 1 ns later, check datapath against history.
   task automatic step(input logic [7:0] a0, input logic [7:0] a1, input logic d,
                       input logic e, input logic rv);
      int d0;
      int d1;
      l0_rx = a0;
      l1_rx = a1;
      dos   = d;
      en    = e;
      rst   = rv;
      h0[cyc] = a0;
      h1[cyc] = a1;
      hd[cyc] = d;
      @(posedge clk);
      #1;
      if (!rv) begin
         m_lane = 0;
         m_val  = 0;
         chk8("rst_lane0_out", l0_out, 8'h00);
         chk8("rst_lane1_out", l1_out, 8'h00);
         chk1("rst_data_os_out", dos_out, 1'b0);
         chk1("rst_rx_valid", rx_valid, 1'b0);
         chk1("rst_deskew_done", done, 1'b0);
         chk1("rst_deskew_err", err, 1'b0);
         chk1("rst_skew_lane", skew_lane, 1'b0);
         chk8("rst_skew_val", {4'h0, skew_val}, 8'h00);
      end else begin
         d0 = (m_lane == 0) ? m_val : 0;
         d1 = (m_lane == 1) ? m_val : 0;
         chk8("lane0_out", l0_out, h0[cyc - d0]);
         chk8("lane1_out", l1_out, h1[cyc - d1]);
         chk1("data_os_out", dos_out, hd[cyc]);
      end
      cyc++;
   endtask

   // Restart via IDLE/SEARCH, marker on the early lane, the late lane then
   // carries the early lane's stream shifted by s cycles.
   task automatic run_lock(input int early, input int s, input int n_after);
      logic [7:0] eh [0:63];
      logic [7:0] eb;
      logic [7:0] lb;
      step(rnd_byte(), rnd_byte(), rnd_bit(), 1'b0, 1'b1);
      chk1("idle_done", done, 1'b0);
      chk1("idle_valid", rx_valid, 1'b0);
      chk1("idle_err", err, 1'b0);
      step(rnd_byte(), rnd_byte(), rnd_bit(), 1'b1, 1'b1);
      for (int i = 0; i <= s + n_after; i++) begin
         eb = (i == 0) ? 8'hF0 : rnd_byte();
         eh[i] = eb;
         lb = (i >= s) ? eh[i - s] : rnd_byte();
         if (early == 0) step(eb, lb, rnd_bit(), 1'b1, 1'b1);
         else            step(lb, eb, rnd_bit(), 1'b1, 1'b1);
         chk1("lock_done", done, i >= s);
         chk1("lock_valid", rx_valid, i >= s + 1);
         chk1("lock_err", err, 1'b0);
         if (i == s) begin
            chk1("skew_lane", skew_lane, (s == 0) ? 1'b0 : 1'(early));
            chk8("skew_val", {4'h0, skew_val}, 8'(s));
            m_lane = (s == 0) ? 0 : early;
            m_val  = s;
         end
         if (i > s) chk8("aligned", l0_out, l1_out);
      end
   endtask

   initial begin
      // Reset held with enable high and markers on both lanes.
      for (int i = 0; i < 3; i++) step(8'hF0, 8'hF0, 1'b1, 1'b1, 1'b0);
      // Release: this edge moves IDLE->SEARCH, the next one sees both markers.
      step(8'hF0, 8'hF0, 1'b1, 1'b1, 1'b1);
      chk1("release_done", done, 1'b0);
      step(8'hF0, 8'hF0, 1'b0, 1'b1, 1'b1);
      chk1("search_lock_done", done, 1'b1);
      chk1("search_lock_valid", rx_valid, 1'b0);
      chk8("search_lock_skew", {4'h0, skew_val}, 8'h00);
      step(rnd_byte(), rnd_byte(), 1'b1, 1'b1, 1'b1);
      chk1("search_lock_valid2", rx_valid, 1'b1);

      run_lock(0, 3, 10);
      run_lock(0, 0, 6);
      run_lock(1, MAXS, 8);

      // Lane 1 marker, lane 0 marker MAX_SKEW+1 cycles later -> ERROR.
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b0, 1'b1);
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b1, 1'b1);
      for (int i = 0; i <= MAXS + 1; i++) begin
         step((i == MAXS + 1) ? 8'hF0 : rnd_byte(), (i == 0) ? 8'hF0 : rnd_byte(),
              rnd_bit(), 1'b1, 1'b1);
         chk1("err_flag", err, i >= MAXS);
         chk1("err_done", done, 1'b0);
         chk1("err_valid", rx_valid, 1'b0);
      end
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b0, 1'b1);
      chk1("err_cleared", err, 1'b0);
      run_lock(0, 3, 8);

      // Enable dropped mid-measure; the next lock must not inherit the count.
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b0, 1'b1);
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b1, 1'b1);
      step(8'hF0, rnd_byte(), 1'b0, 1'b1, 1'b1);
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b1, 1'b1);
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b1, 1'b1);
      run_lock(1, 4, 6);

      // Lock at 5; the following run_lock opens with enable low and checks
      // that done/valid fall on the next cycle.
      run_lock(0, 5, 6);
      for (int k = 0; k < 5; k++) begin
         run_lock(int'($urandom_range(0, 1)), int'($urandom_range(0, MAXS)), 6);
      end

      // Reset in the middle of a locked run behaves as power-on reset.
      step(rnd_byte(), rnd_byte(), 1'b1, 1'b1, 1'b0);
      step(rnd_byte(), rnd_byte(), 1'b1, 1'b1, 1'b0);
      step(rnd_byte(), rnd_byte(), 1'b0, 1'b1, 1'b1);
      chk1("post_rst_done", done, 1'b0);
      run_lock(1, 2, 6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
